if_stage: RTL and testbench



---
 rtl/if_stage.sv | 179 +++++++++++++++++
 tb/tb_if_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the 3-stage pipelined RISC-V core.
//
// Owns the program counter. It issues instruction-memory requests and absorbs
// memory wait states. Downstream stalls are absorbed with a one-entry skid
// buffer. Branch/jump redirects from the execute stage are applied here. The
// stage drives the IF/EX pipeline register that the datapath consumes.
//
// Ports
//   clk1        in   clock, rising edge
//   reset1      in   asynchronous, active-high reset
//   stall       in   datapath cannot accept a new instruction this cycle
//   br_taken    in   redirect request from execute stage
//   br_target   in   redirect address (low two bits ignored)
//   imem_req    out  fetch request valid
//   imem_addr   out  fetch address (equals PC)
//   imem_ready  in   imem_rdata valid for the current request this cycle
//   imem_rdata  in   fetched instruction
//   PC          out  current fetch PC
//   pc_ex       out  PC of instruction in IF/EX register
//   instr_ex    out  instruction in IF/EX register
//   valid_ex    out  IF/EX register holds a real instruction
// ----------------------------------------------------------------------------
module if_stage #(
    parameter int unsigned                addr_data_width = 32,
    parameter logic [addr_data_width-1:0] RESET_PC        = '0,
    parameter logic [31:0]                NOP_INSTR       = 32'h0000_0013
) (
    input  logic                       clk1,
    input  logic                       reset1,
    input  logic                       stall,
    input  logic                       br_taken,
    input  logic [addr_data_width-1:0] br_target,
    output logic                       imem_req,
    output logic [addr_data_width-1:0] imem_addr,
    input  logic                       imem_ready,
    input  logic [31:0]                imem_rdata,
    output logic [addr_data_width-1:0] PC,
    output logic [addr_data_width-1:0] pc_ex,
    output logic [31:0]                instr_ex,
    output logic                       valid_ex
);

    // START : idle for one edge after reset, no request.
    // FETCH : request outstanding at PC.
    // HOLD  : skid buffer full, waiting for the datapath to release its stall.
    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic [addr_data_width-1:0] r_pc;
    logic [addr_data_width-1:0] r_pc_ex;
    logic [31:0]                r_instr_ex;
    logic                       r_valid_ex;
    logic [addr_data_width-1:0] r_skid_pc;
    logic [31:0]                r_skid_instr;

    logic                       w_redirect;
    logic [addr_data_width-1:0] w_redirect_pc;
    logic [addr_data_width-1:0] w_pc_plus4;

    // A redirect is meaningless before the first fetch has started.
    assign w_redirect    = br_taken && (r_state != ST_START);
    // The target is forced onto a word boundary so PC[1:0] stays zero.
    assign w_redirect_pc = br_target & {{(addr_data_width-2){1'b1}}, 2'b00};
    // Modulo 2^W increment: the top word wraps to zero silently.
    assign w_pc_plus4    = r_pc + addr_data_width'(4);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            r_state <= ST_START;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches even when a branch forgets to assign.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_START: w_state_next = ST_FETCH;
            ST_FETCH: begin
                if (w_redirect) begin
                    w_state_next = ST_FETCH;
                end else if (imem_ready && stall) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_redirect || !stall) begin
                    w_state_next = ST_FETCH;
                end
            end
            default: w_state_next = ST_START;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        imem_req = 1'b0;
        if (r_state == ST_FETCH) begin
            imem_req = 1'b1;
        end
    end

    assign imem_addr = r_pc;
    assign PC        = r_pc;
    assign pc_ex     = r_pc_ex;
    assign instr_ex  = r_instr_ex;
    assign valid_ex  = r_valid_ex;

    // ------------------------------------------------------------------
    // PC, IF/EX register and skid buffer
    // ------------------------------------------------------------------
    // The skid buffer needs no valid bit: it is full exactly while in HOLD.
    // NOTE: the skid registers are reset as well, even though their content
    // is never consumed while empty, so no output can ever show X.
    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            r_pc         <= RESET_PC;
            r_pc_ex      <= '0;
            r_instr_ex   <= NOP_INSTR;
            r_valid_ex   <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= NOP_INSTR;
        end else if (w_redirect) begin
            // Redirect beats stall and memory response; a same-cycle
            // response and any skid content are simply dropped.
            r_pc       <= w_redirect_pc;
            r_instr_ex <= NOP_INSTR;
            r_valid_ex <= 1'b0;
        end else begin
            unique case (r_state)
                ST_FETCH: begin
                    if (imem_ready && !stall) begin
                        r_pc_ex    <= r_pc;
                        r_instr_ex <= imem_rdata;
                        r_valid_ex <= 1'b1;
                        r_pc       <= w_pc_plus4;
                    end else if (imem_ready && stall) begin
                        // Park the response; IF/EX keeps the stalled instruction.
                        r_skid_pc    <= r_pc;
                        r_skid_instr <= imem_rdata;
                        r_pc         <= w_pc_plus4;
                    end else if (!stall) begin
                        // Wait state with a free datapath: issue a bubble.
                        r_instr_ex <= NOP_INSTR;
                        r_valid_ex <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        r_pc_ex    <= r_skid_pc;
                        r_instr_ex <= r_skid_instr;
                        r_valid_ex <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage : directed scoreboard bench for if_stage.
//
// The driver applies one vector per clock and pushes the hand-computed
// post-edge outputs into a queue. The monitor wakes shortly after every rising
// edge and compares the DUT against the queued entry. A second instance, built
// with RESET_PC = 0xFFFF_FFF8 and free-running, exercises the PC wrap.
// ----------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'h5A00_0000;

    typedef struct {
        string       name;
        logic        req;
        logic [31:0] pc;
        logic [31:0] pc_ex;
        logic [31:0] instr;
        logic        valid;
        logic        chk_w;
        logic [31:0] pc_w;
        logic [31:0] pc_ex_w;
    } exp_t;

    logic        clk1 = 1'b0;
    logic        reset1;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_ex;
    logic [31:0] instr_ex;
    logic        valid_ex;

    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic [31:0] imem_rdata_w;
    logic [31:0] pc_w;
    logic [31:0] pc_ex_w;
    logic [31:0] instr_ex_w;
    logic        valid_ex_w;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    event mon_ev;

    // Memory model: the word returned is the address tagged with KEY, so a
    // mix-up between address and data cannot go unnoticed.
    assign imem_rdata   = imem_addr ^ KEY;
    assign imem_rdata_w = imem_addr_w ^ KEY;

    if_stage dut (
        .clk1       (clk1),
        .reset1     (reset1),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .PC         (pc),
        .pc_ex      (pc_ex),
        .instr_ex   (instr_ex),
        .valid_ex   (valid_ex)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk1       (clk1),
        .reset1     (reset1),
        .stall      (1'b0),
        .br_taken   (1'b0),
        .br_target  (32'h0),
        .imem_req   (imem_req_w),
        .imem_addr  (imem_addr_w),
        .imem_ready (1'b1),
        .imem_rdata (imem_rdata_w),
        .PC         (pc_w),
        .pc_ex      (pc_ex_w),
        .instr_ex   (instr_ex_w),
        .valid_ex   (valid_ex_w)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input string nm, input logic req, input logic [31:0] p,
                                input logic [31:0] pe, input logic [31:0] ins, input logic v);
        exp_t e;
        e.name = nm; e.req = req; e.pc = p; e.pc_ex = pe; e.instr = ins; e.valid = v;
        e.chk_w = 1'b0; e.pc_w = '0; e.pc_ex_w = '0;
        return e;
    endfunction

    function automatic exp_t mkw(input exp_t e0, input logic [31:0] pw, input logic [31:0] pew);
        exp_t e;
        e = e0; e.chk_w = 1'b1; e.pc_w = pw; e.pc_ex_w = pew;
        return e;
    endfunction

    // Apply inputs at a falling edge, queue the outputs expected after the
    // following rising edge, and return at the next falling edge.
    task automatic step(input logic st, input logic br, input logic [31:0] tgt,
                        input logic rdy, input exp_t e);
        stall      = st;
        br_taken   = br;
        br_target  = tgt;
        imem_ready = rdy;
        q.push_back(e);
        @(negedge clk1);
    endtask

    always @(posedge clk1) begin
        #1;
        ->mon_ev;
    end

    // Monitor / scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(mon_ev);
            if (q.size() != 0) begin
                e = q.pop_front();
                check({e.name, ".req"},      {31'h0, imem_req}, {31'h0, e.req});
                check({e.name, ".pc"},       pc,                e.pc);
                if (e.req) check({e.name, ".addr"}, imem_addr, e.pc);
                check({e.name, ".pc_ex"},    pc_ex,             e.pc_ex);
                check({e.name, ".instr_ex"}, instr_ex,          e.instr);
                check({e.name, ".valid_ex"}, {31'h0, valid_ex}, {31'h0, e.valid});
                if (e.chk_w) begin
                    check({e.name, ".wrap_pc"},    pc_w,    e.pc_w);
                    check({e.name, ".wrap_pc_ex"}, pc_ex_w, e.pc_ex_w);
                end
            end
        end
    end

    initial begin
        reset1     = 1'b1;
        stall      = 1'b0;
        br_taken   = 1'b0;
        br_target  = '0;
        imem_ready = 1'b1;
        @(negedge clk1);
        @(negedge clk1);

        // Reset state held across an edge (START, no request).
        step(0, 0, 0, 1, mkw(mk("reset", 0, 32'h0, 32'h0, NOP, 0), 32'hFFFF_FFF8, 32'h0));
        reset1 = 1'b0;

        // Free run: START -> FETCH, then one instruction per clock.
        step(0, 0, 0, 1, mkw(mk("e1_start", 1, 32'h0, 32'h0, NOP, 0), 32'hFFFF_FFF8, 32'h0));
        step(0, 0, 0, 1, mkw(mk("e2_f0", 1, 32'h4, 32'h0, 32'h0 ^ KEY, 1), 32'hFFFF_FFFC, 32'hFFFF_FFF8));
        step(0, 0, 0, 1, mkw(mk("e3_f4", 1, 32'h8, 32'h4, 32'h4 ^ KEY, 1), 32'h0000_0000, 32'hFFFF_FFFC));

        // Two wait states at PC=0x8: PC holds, two bubbles.
        step(0, 0, 0, 0, mkw(mk("e4_wait", 1, 32'h8, 32'h4, NOP, 0), 32'h0000_0004, 32'h0000_0000));
        step(0, 0, 0, 0, mkw(mk("e5_wait", 1, 32'h8, 32'h4, NOP, 0), 32'h0000_0008, 32'h0000_0004));
        step(0, 0, 0, 1, mk("e6_f8", 1, 32'hC, 32'h8, 32'h8 ^ KEY, 1));
        step(0, 0, 0, 1, mk("e7_fc", 1, 32'h10, 32'hC, 32'hC ^ KEY, 1));

        // Stall with skid at PC=0x10, held three cycles, then released.
        step(1, 0, 0, 1, mk("e8_skid", 0, 32'h14, 32'hC, 32'hC ^ KEY, 1));
        step(1, 0, 0, 1, mk("e9_hold", 0, 32'h14, 32'hC, 32'hC ^ KEY, 1));
        step(1, 0, 0, 1, mk("e10_hold", 0, 32'h14, 32'hC, 32'hC ^ KEY, 1));
        step(0, 0, 0, 1, mk("e11_unskid", 1, 32'h14, 32'h10, 32'h10 ^ KEY, 1));
        step(0, 0, 0, 1, mk("e12_f14", 1, 32'h18, 32'h14, 32'h14 ^ KEY, 1));

        // Redirect while in HOLD with stall still high: skid (0x18) dropped.
        step(1, 0, 0, 1, mk("e13_skid", 0, 32'h1C, 32'h14, 32'h14 ^ KEY, 1));
        step(1, 1, 32'h103, 1, mk("e14_br_hold", 1, 32'h100, 32'h14, NOP, 0));
        step(0, 0, 0, 1, mk("e15_f100", 1, 32'h104, 32'h100, 32'h100 ^ KEY, 1));

        // Redirect during a wait state; the same-cycle response is dropped.
        step(0, 0, 0, 0, mk("e16_wait", 1, 32'h104, 32'h100, NOP, 0));
        step(1, 1, 32'h202, 1, mk("e17_br_rsp", 1, 32'h200, 32'h100, NOP, 0));
        step(0, 0, 0, 1, mk("e18_f200", 1, 32'h204, 32'h200, 32'h200 ^ KEY, 1));

        // No response and stall: everything holds.
        step(1, 0, 0, 0, mk("e19_idle", 1, 32'h204, 32'h200, 32'h200 ^ KEY, 1));

        // Enter HOLD, then assert reset between edges.
        step(1, 0, 0, 1, mk("e20_skid", 0, 32'h208, 32'h200, 32'h200 ^ KEY, 1));
        #2;
        reset1 = 1'b1;
        #1;
        q.push_back(mk("async_rst", 0, 32'h0, 32'h0, NOP, 0));
        ->mon_ev;
        @(negedge clk1);
        reset1 = 1'b0;

        // Restart from reset: skid content (0x204) must be gone.
        step(1, 0, 0, 1, mk("r1_start", 1, 32'h0, 32'h0, NOP, 0));
        step(0, 0, 0, 1, mk("r2_f0", 1, 32'h4, 32'h0, 32'h0 ^ KEY, 1));

        @(negedge clk1);
        check("queue_drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
